// File: rtl/smu_pkg.sv
// smu_pkg: shared types for the sequence matcher.
//   cmp_op_e    - per-stage comparison operator encoding (matches cfg_op bits).
//   smu_state_e - matcher FSM states.
package smu_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_LT = 2'b01,
    CMP_GT = 2'b10,
    CMP_NE = 2'b11
  } cmp_op_e;

  typedef enum logic [1:0] {
    SMU_IDLE  = 2'b00,
    SMU_ARMED = 2'b01,
    SMU_DONE  = 2'b10
  } smu_state_e;

endpackage

// File: rtl/smu_cmp_stage.sv
// smu_cmp_stage: purely combinational masked comparator for one stage.
//   obs  - observable bus sample
//   mask - bits taking part in the comparison
//   val  - reference value
//   op   - EQ / LT / GT / NE, unsigned on the masked operands
//   hit  - comparison result
module smu_cmp_stage
  import smu_pkg::*;
#(
  parameter int unsigned K = 8
) (
  input  logic [K-1:0] obs,
  input  logic [K-1:0] mask,
  input  logic [K-1:0] val,
  input  cmp_op_e      op,
  output logic         hit
);

  logic [K-1:0] a;
  logic [K-1:0] b;

  always_comb begin
    a   = obs & mask;
    b   = val & mask;
    hit = 1'b0;
    case (op)
      CMP_EQ:  hit = (a == b);
      CMP_LT:  hit = (a <  b);
      CMP_GT:  hit = (a >  b);
      CMP_NE:  hit = (a != b);
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/smu_seq_matcher.sv
// smu_seq_matcher: multi-stage ordered sequence matcher on a K-bit bus.
//   clk, reset  - clock, synchronous active-high reset
//   en          - enable; low forces IDLE (sticky flag and counter kept)
//   obs_i       - observable bus
//   cfg_mask/val/op - per-stage compare config, stage s at [s*K +: K] / [2*s +: 2]
//   cfg_len     - active stage count (0 -> 1, >N -> N)
//   cfg_window  - max consecutive non-matching cycles between stages, 0 = unlimited
//   cfg_rearm   - 0 one-shot (hold in DONE), 1 restart at stage 0 after trigger
//   trig_clr    - clears trig_sticky and trig_count
//   stage_o     - current stage index
//   done_o      - high while in DONE
//   trigger     - registered one-cycle pulse on final-stage match
//   timeout     - registered one-cycle pulse on window expiry
//   trig_sticky - latched trigger flag
//   trig_count  - saturating trigger counter
module smu_seq_matcher
  import smu_pkg::*;
#(
  parameter int unsigned K  = 8,
  parameter int unsigned N  = 4,
  parameter int unsigned TW = 8,
  parameter int unsigned CW = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [K-1:0]           obs_i,
  input  logic [N*K-1:0]         cfg_mask,
  input  logic [N*K-1:0]         cfg_val,
  input  logic [2*N-1:0]         cfg_op,
  input  logic [$clog2(N):0]     cfg_len,
  input  logic [TW-1:0]          cfg_window,
  input  logic                   cfg_rearm,
  input  logic                   trig_clr,
  output logic [$clog2(N)-1:0]   stage_o,
  output logic                   done_o,
  output logic                   trigger,
  output logic                   timeout,
  output logic                   trig_sticky,
  output logic [CW-1:0]          trig_count
);

  localparam int unsigned SW = $clog2(N);
  localparam int unsigned LW = SW + 1;

  smu_state_e    state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [TW-1:0] win_q, win_d;
  logic          trigger_q, trigger_d;
  logic          timeout_q, timeout_d;
  logic          sticky_q, sticky_d;
  logic [CW-1:0] count_q, count_d;

  logic [N-1:0]  hit_vec;
  logic          stage_hit;
  logic [LW-1:0] len_eff;
  logic [LW-1:0] last_stage;
  logic          at_last;
  logic [CW-1:0] count_base;

  for (genvar g = 0; g < N; g++) begin : g_stage
    smu_cmp_stage #(.K(K)) u_cmp (
      .obs  (obs_i),
      .mask (cfg_mask[g*K +: K]),
      .val  (cfg_val[g*K +: K]),
      .op   (cmp_op_e'(cfg_op[2*g +: 2])),
      .hit  (hit_vec[g])
    );
  end

  always_comb begin
    if (cfg_len == '0) begin
      len_eff = LW'(1);
    end else if (cfg_len > LW'(N)) begin
      len_eff = LW'(N);
    end else begin
      len_eff = cfg_len;
    end
    last_stage = len_eff - LW'(1);
    at_last    = ({1'b0, stage_q} == last_stage);
    stage_hit  = hit_vec[stage_q];
    // Clear is applied first so a coincident final match counts from zero.
    count_base = trig_clr ? '0 : count_q;
  end

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    win_d     = win_q;
    trigger_d = 1'b0;
    timeout_d = 1'b0;
    sticky_d  = trig_clr ? 1'b0 : sticky_q;
    count_d   = count_base;

    if (!en) begin
      state_d = SMU_IDLE;
      stage_d = '0;
      win_d   = '0;
    end else begin
      case (state_q)
        SMU_IDLE: begin
          state_d = SMU_ARMED;
          stage_d = '0;
          win_d   = '0;
        end
        SMU_ARMED: begin
          if (stage_hit) begin
            win_d = '0;
            if (at_last) begin
              trigger_d = 1'b1;
              sticky_d  = 1'b1;
              if (count_base != '1) begin
                count_d = count_base + CW'(1);
              end
              stage_d = '0;
              state_d = cfg_rearm ? SMU_ARMED : SMU_DONE;
            end else begin
              stage_d = stage_q + SW'(1);
            end
          end else if (stage_q == '0) begin
            win_d = '0;
          end else if ((cfg_window != '0) && (win_q == cfg_window - TW'(1))) begin
            // win_q counts earlier misses, so this is the cfg_window-th miss.
            stage_d   = '0;
            win_d     = '0;
            timeout_d = 1'b1;
          end else if (win_q != '1) begin
            win_d = win_q + TW'(1);
          end
        end
        SMU_DONE: begin
          if (trig_clr || cfg_rearm) begin
            state_d = SMU_ARMED;
            stage_d = '0;
            win_d   = '0;
          end
        end
        default: begin
          state_d = SMU_IDLE;
          stage_d = '0;
          win_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SMU_IDLE;
      stage_q   <= '0;
      win_q     <= '0;
      trigger_q <= 1'b0;
      timeout_q <= 1'b0;
      sticky_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      win_q     <= win_d;
      trigger_q <= trigger_d;
      timeout_q <= timeout_d;
      sticky_q  <= sticky_d;
      count_q   <= count_d;
    end
  end

  assign stage_o     = stage_q;
  assign done_o      = (state_q == SMU_DONE);
  assign trigger     = trigger_q;
  assign timeout     = timeout_q;
  assign trig_sticky = sticky_q;
  assign trig_count  = count_q;

endmodule

// File: tb/tb_smu_seq_matcher.sv
module tb_smu_seq_matcher;

  localparam int unsigned K  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned TW = 8;
  localparam int unsigned CW = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 en;
  logic [K-1:0]         obs_i;
  logic [N*K-1:0]       cfg_mask;
  logic [N*K-1:0]       cfg_val;
  logic [2*N-1:0]       cfg_op;
  logic [$clog2(N):0]   cfg_len;
  logic [TW-1:0]        cfg_window;
  logic                 cfg_rearm;
  logic                 trig_clr;
  logic [$clog2(N)-1:0] stage_o;
  logic                 done_o;
  logic                 trigger;
  logic                 timeout;
  logic                 trig_sticky;
  logic [CW-1:0]        trig_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  smu_seq_matcher #(.K(K), .N(N), .TW(TW), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .obs_i       (obs_i),
    .cfg_mask    (cfg_mask),
    .cfg_val     (cfg_val),
    .cfg_op      (cfg_op),
    .cfg_len     (cfg_len),
    .cfg_window  (cfg_window),
    .cfg_rearm   (cfg_rearm),
    .trig_clr    (trig_clr),
    .stage_o     (stage_o),
    .done_o      (done_o),
    .trigger     (trigger),
    .timeout     (timeout),
    .trig_sticky (trig_sticky),
    .trig_count  (trig_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic set_stage(input int s, input logic [K-1:0] m, input logic [K-1:0] v,
                           input logic [1:0] op);
    cfg_mask[s*K +: K] = m;
    cfg_val[s*K +: K]  = v;
    cfg_op[2*s +: 2]   = op;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; obs_i = '0; trig_clr = 1'b0;
    cfg_mask = '0; cfg_val = '0; cfg_op = '0;
    cfg_len = '0; cfg_window = '0; cfg_rearm = 1'b0;
    tick(); tick();
    chk("rst_stage", 32'(stage_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_trigger", 32'(trigger), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_sticky", 32'(trig_sticky), 0);
    chk("rst_count", 32'(trig_count), 0);

    // Stage 0 EQ 0x12, stage 1 GT 0x40, stage 2 NE 0x00, stage 3 EQ 0x77
    set_stage(0, 8'hFF, 8'h12, 2'b00);
    set_stage(1, 8'hFF, 8'h40, 2'b10);
    set_stage(2, 8'hFF, 8'h00, 2'b11);
    set_stage(3, 8'hFF, 8'h77, 2'b00);
    cfg_len = 3; cfg_window = 0; cfg_rearm = 1'b0;
    reset = 1'b0;
    tick();
    en = 1'b1; obs_i = 8'h00; tick();
    chk("arm_stage", 32'(stage_o), 0);
    obs_i = 8'h12; tick();
    chk("seq_s1", 32'(stage_o), 1);
    chk("seq_s1_trig", 32'(trigger), 0);
    obs_i = 8'h50; tick();
    chk("seq_s2", 32'(stage_o), 2);
    obs_i = 8'h01; tick();
    chk("seq_trig", 32'(trigger), 1);
    chk("seq_count", 32'(trig_count), 1);
    chk("seq_sticky", 32'(trig_sticky), 1);
    chk("seq_done", 32'(done_o), 1);
    chk("seq_stage0", 32'(stage_o), 0);
    obs_i = 8'h00; tick();
    chk("trig_pulse_end", 32'(trigger), 0);
    chk("done_hold", 32'(done_o), 1);

    // Leave DONE through cfg_rearm
    cfg_rearm = 1'b1; tick();
    chk("rearm_done", 32'(done_o), 0);
    chk("rearm_count", 32'(trig_count), 1);

    // trig_clr coincident with final match: clear then increment
    obs_i = 8'h12; tick();
    obs_i = 8'h50; tick();
    obs_i = 8'h01; trig_clr = 1'b1; tick();
    trig_clr = 1'b0;
    chk("clr_match_trig", 32'(trigger), 1);
    chk("clr_match_sticky", 32'(trig_sticky), 1);
    chk("clr_match_count", 32'(trig_count), 1);
    chk("clr_match_rearm", 32'(done_o), 0);

    // en drop mid-sequence
    obs_i = 8'h12; tick();
    obs_i = 8'h50; tick();
    chk("mid_s2", 32'(stage_o), 2);
    en = 1'b0; tick();
    chk("en_drop_stage", 32'(stage_o), 0);
    chk("en_drop_count", 32'(trig_count), 1);
    chk("en_drop_sticky", 32'(trig_sticky), 1);
    en = 1'b1; obs_i = 8'h12; tick();
    chk("idle_no_cmp", 32'(stage_o), 0);

    // Window = 3: timeout after three misses
    en = 1'b0; cfg_window = 3; tick();
    en = 1'b1; tick();
    obs_i = 8'h12; tick();
    chk("win_s1", 32'(stage_o), 1);
    obs_i = 8'h00; tick();
    chk("win_miss1", 32'(timeout), 0);
    tick();
    chk("win_miss2", 32'(timeout), 0);
    chk("win_miss2_stage", 32'(stage_o), 1);
    tick();
    chk("win_timeout", 32'(timeout), 1);
    chk("win_to_stage", 32'(stage_o), 0);
    chk("win_no_trig", 32'(trigger), 0);
    tick();
    chk("win_to_pulse_end", 32'(timeout), 0);

    // Match on the last window cycle wins over expiry
    obs_i = 8'h12; tick();
    obs_i = 8'h00; tick(); tick();
    obs_i = 8'h50; tick();
    chk("win_match_stage", 32'(stage_o), 2);
    chk("win_match_no_to", 32'(timeout), 0);
    cfg_rearm = 1'b0; obs_i = 8'h01; tick();
    chk("win_seq_trig", 32'(trigger), 1);
    chk("win_seq_count", 32'(trig_count), 2);
    chk("win_seq_done", 32'(done_o), 1);

    // trig_clr in DONE
    obs_i = 8'h00; trig_clr = 1'b1; tick();
    trig_clr = 1'b0;
    chk("done_clr_sticky", 32'(trig_sticky), 0);
    chk("done_clr_count", 32'(trig_count), 0);
    chk("done_clr_done", 32'(done_o), 0);

    // cfg_len = 7 clamps to 4 stages
    en = 1'b0; cfg_len = 7; cfg_window = 0; tick();
    en = 1'b1; tick();
    obs_i = 8'h12; tick();
    obs_i = 8'h50; tick();
    obs_i = 8'h01; tick();
    chk("len7_no_trig", 32'(trigger), 0);
    chk("len7_s3", 32'(stage_o), 3);
    obs_i = 8'h77; tick();
    chk("len7_trig", 32'(trigger), 1);
    chk("len7_count", 32'(trig_count), 1);

    // Reset mid-sequence
    en = 1'b0; cfg_len = 3; tick();
    en = 1'b1; tick();
    obs_i = 8'h12; tick();
    obs_i = 8'h50; tick();
    chk("rst_mid_s2", 32'(stage_o), 2);
    reset = 1'b1; tick();
    chk("rst_mid_stage", 32'(stage_o), 0);
    chk("rst_mid_count", 32'(trig_count), 0);
    chk("rst_mid_sticky", 32'(trig_sticky), 0);
    chk("rst_mid_done", 32'(done_o), 0);
    reset = 1'b0; en = 1'b0; tick();

    // cfg_len = 0 behaves as one stage; stage 0 LT 0x05 under mask 0x0F
    set_stage(0, 8'h0F, 8'h05, 2'b01);
    cfg_len = 0; cfg_rearm = 1'b0; tick();
    en = 1'b1; tick();
    obs_i = 8'hF3; tick();
    chk("len0_trig", 32'(trigger), 1);
    chk("len0_done", 32'(done_o), 1);
    tick();
    chk("len0_oneshot", 32'(trigger), 0);

    // Auto-rearm every cycle, counter saturates
    en = 1'b0; cfg_len = 1; cfg_rearm = 1'b1; trig_clr = 1'b1; tick();
    trig_clr = 1'b0; en = 1'b1; tick();
    chk("sat_start", 32'(trig_count), 0);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 9) chk("sat_cnt10", 32'(trig_count), 10);
      if (i == 254) chk("sat_cnt255", 32'(trig_count), 255);
    end
    chk("sat_trig", 32'(trigger), 1);
    chk("sat_count", 32'(trig_count), 255);
    chk("sat_stage", 32'(stage_o), 0);

    en = 1'b0; tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/smu_seq_matcher.md
Name: smu_seq_matcher

Overview:
- Multi-stage sequence matcher for the SoC patch observability path.
- Watches a K-bit observable bus and steps through up to N programmable comparison stages, each with its own mask, value and operator.
- Fires a trigger when the configured number of stages match in order.
- Adds an inter-stage timeout window, one-shot/auto-rearm modes, a sticky trigger and a saturating trigger counter; feeds the downstream patch/control unit.

Parameters:
- K, 8, observable bus width in bits.
- N, 4, maximum number of sequence stages (N >= 2).
- TW, 8, width of the inter-stage window counter.
- CW, 8, width of the trigger event counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  matcher enable; low forces the matcher to idle.
- obs_i  in  K  observable signal input.
- cfg_mask  in  N*K  per-stage compare mask; stage s uses bits [s*K +: K].
- cfg_val  in  N*K  per-stage compare value, same slicing as cfg_mask.
- cfg_op  in  2*N  per-stage operator: 00 EQ, 01 LT, 10 GT, 11 NE.
- cfg_len  in  $clog2(N)+1  number of active stages.
- cfg_window  in  TW  maximum idle cycles allowed between stage matches; 0 means unlimited.
- cfg_rearm  in  1  0 = one-shot (hold in DONE), 1 = auto-rearm to stage 0.
- trig_clr  in  1  clears trig_sticky and trig_count.
- stage_o  out  $clog2(N)  current stage index.
- done_o  out  1  high while in DONE.
- trigger  out  1  single-cycle trigger pulse.
- timeout  out  1  single-cycle pulse when the window expires.
- trig_sticky  out  1  latched trigger flag.
- trig_count  out  CW  saturating count of triggers.

Behaviour:
- Reset values: state IDLE, stage_o=0, window counter=0, all outputs 0.
- Comparison for stage s:
  - a = obs_i & mask_s, b = val_s & mask_s, compared unsigned.
  - EQ: a==b. LT: a<b. GT: a>b. NE: a!=b.
  - The comparison itself is purely combinational.
- Effective length L:
  - cfg_len=0 is treated as L=1.
  - cfg_len>N is clamped to L=N.
  - cfg_len is sampled every cycle.
- FSM states: IDLE, ARMED(stage s), DONE.
  - IDLE: if en=1, go to ARMED with s=0 on the next cycle. No compare is evaluated in IDLE.
  - ARMED, match on stage s with s<L-1: s <= s+1 and the window counter is cleared.
  - ARMED, match on stage s with s==L-1: trigger=1 next cycle, trig_sticky<=1, trig_count<=trig_count+1 (saturating at all-ones). Then go to s=0 if cfg_rearm=1, otherwise go to DONE.
  - ARMED, no match with s==0: stay in stage 0; the counter holds at 0.
  - ARMED, no match with s>0: the counter increments. If cfg_window!=0 and the counter reaches cfg_window-1 in that cycle, go to s=0, clear the counter and pulse timeout next cycle. That is, timeout occurs after cfg_window consecutive non-matching cycles.
  - DONE: hold, with done_o=1. Leave for s=0 on trig_clr=1 or when cfg_rearm becomes 1.
- en=0 in any state: next state IDLE, s=0, counter=0. trig_sticky and trig_count are retained.
- Latency: trigger and timeout are registered, one cycle after the qualifying obs_i sample.
- trig_clr with a simultaneous final-stage match: the trigger wins. trig_sticky=1 and trig_count=1 (the clear is applied before the increment).
- A match and a window expiry in the same cycle: the match wins; no timeout.
- The window counter saturates and never wraps when cfg_window=0.
- Reset mid-sequence returns everything to reset values on the next edge.
- Configuration inputs are not registered. Software changes them only while en=0; behaviour is undefined otherwise, except for cfg_rearm in DONE.

Decomposition:
- Package smu_pkg:
  - cmp_op_e enum (CMP_EQ, CMP_LT, CMP_GT, CMP_NE).
  - smu_state_e enum (SMU_IDLE, SMU_ARMED, SMU_DONE).
- Sub-module smu_cmp_stage (parameter K): inputs obs, mask, val, op; output hit.
  - Instantiated N times via generate. The FSM selects hit[s].

Test Plan:
- K=8, N=4, L=3, rearm=0, window=0. Stage 0 EQ 0x12, stage 1 GT 0x40, stage 2 NE 0x00, all masks 0xFF. Drive 0x12, 0x50, 0x01 on consecutive cycles -> trigger one cycle after 0x01, trig_count=1, done_o=1, stage_o=0.
- Same configuration, window=3. Drive 0x12, then 0x00 for three cycles -> timeout pulse after the third 0x00, stage_o=0, no trigger.
- rearm=1, L=1, stage 0 LT 0x05 with mask 0x0F. Drive 0xF3 for 300 cycles -> a trigger every cycle; trig_count saturates at 0xFF.
- In DONE, assert trig_clr -> trig_sticky=0, trig_count=0, done_o=0. Next, assert trig_clr in the same cycle as a final match -> trig_sticky=1, trig_count=1.
- Mid-sequence at stage 2, drop en for 1 cycle -> stage_o=0 and IDLE, trig_count retained. Repeat with reset=1 -> all outputs 0.
- cfg_len=0 and cfg_len=7 (N=4) -> behaviour identical to L=1 and L=4 respectively.
